// File: rtl/riscv_wb_pkg.sv
// Shared definitions for the RISC-V writeback arbiter.
// Grant encoding and LSU buffer depth.
package riscv_wb_pkg;

    localparam int WB_FIFO_DEPTH = 2;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } wb_gnt_e;

endpackage

// File: rtl/riscv_wb_fifo.sv
// Two-entry in-order buffer for LSU writeback results.
// Push and pop in the same cycle leave the count unchanged.
module riscv_wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [WB_FIFO_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/riscv_wb_arb.sv
// Writeback arbiter: round-robin ALU vs buffered LSU onto one RF port.
// Define RISCV_WB_SCOREBOARD_EN to build the busy-register scoreboard.
module riscv_wb_arb
    import riscv_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2
);

    localparam int         EW      = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [1:0] DEPTH_C = 2'(WB_FIFO_DEPTH);

    logic [1:0]            fifo_cnt;
    logic [EW-1:0]         fifo_head;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  fifo_empty;
    logic                  lsu_push;

    wb_gnt_e               last_q;
    wb_gnt_e               last_d;
    logic                  gnt_alu;
    logic                  gnt_lsu;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  wr_en_q;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    assign lsu_ready  = fifo_cnt < DEPTH_C;
    assign lsu_push   = lsu_valid && lsu_ready;
    assign fifo_empty = fifo_cnt == 2'd0;

    riscv_wb_fifo #(
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (lsu_push),
        .data_i  ({lsu_rd, lsu_data}),
        .pop_i   (gnt_lsu),
        .data_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    assign {head_rd, head_data} = fifo_head;

    // ALU may only go when the LSU is idle or had the previous turn.
    assign alu_ready = fifo_empty || (last_q == GNT_LSU);
    assign gnt_alu   = alu_valid && alu_ready;
    assign gnt_lsu   = !fifo_empty && !gnt_alu;

    always_comb begin
        sel_rd   = head_rd;
        sel_data = head_data;
        last_d   = last_q;
        unique case (1'b1)
            gnt_alu: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
                last_d   = GNT_ALU;
            end
            gnt_lsu: begin
                last_d   = GNT_LSU;
            end
            default: ;
        endcase
    end

    // x0 results are consumed but never written.
    assign wr_en_d = (gnt_alu || gnt_lsu) && (sel_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= GNT_ALU;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            last_q  <= last_d;
            wr_en_q <= wr_en_d;
            if (gnt_alu || gnt_lsu) begin
                wr_addr_q <= sel_rd;
                wr_data_q <= sel_data;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef RISCV_WB_SCOREBOARD_EN
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear first so a same-edge issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_d) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign chk_busy1 = busy_q[chk_addr1] && (chk_addr1 != '0);
    assign chk_busy2 = busy_q[chk_addr2] && (chk_addr2 != '0);
`else
    logic unused_sb;

    assign unused_sb = ^{iss_valid, iss_rd, chk_addr1, chk_addr2};
    assign chk_busy1 = 1'b0;
    assign chk_busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_wb_arb.sv
// Directed self-checking bench for riscv_wb_arb.
// Covers the scoreboard only when RISCV_WB_SCOREBOARD_EN is defined.
module tb_riscv_wb_arb;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic [AW-1:0] chk_addr1;
    logic [AW-1:0] chk_addr2;
    logic          chk_busy1;
    logic          chk_busy2;

    int errs   = 0;
    int checks = 0;

    logic [AW-1:0] wq_a [$];
    logic [DW-1:0] wq_d [$];

    riscv_wb_arb #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .chk_busy1 (chk_busy1),
        .chk_busy2 (chk_busy2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wq_a.push_back(wr_addr);
            wq_d.push_back(wr_data);
        end
    end

    task automatic expect_eq(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic qclear();
        wq_a.delete();
        wq_d.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  ai;
        int  li;
        logic hs_a;
        logic hs_l;
        logic seen;

        rst_n     = 1'b0;
        chk_addr1 = AW'(7);
        chk_addr2 = '0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        expect_eq("rst_wr_en", 64'(wr_en), 64'd0);
        expect_eq("rst_wr_addr", 64'(wr_addr), 64'd0);
        expect_eq("rst_wr_data", wr_data, 64'd0);
        expect_eq("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        expect_eq("rst_alu_ready", 64'(alu_ready), 64'd1);
        expect_eq("rst_busy1", 64'(chk_busy1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU only, rd 3
        @(negedge clk);
        alu_valid = 1'b1;
        alu_rd    = AW'(3);
        alu_data  = DW'(64'hA5);
        #1;
        expect_eq("alu_ready_3", 64'(alu_ready), 64'd1);
        @(negedge clk);
        idle();
        #1;
        expect_eq("alu_wr_en", 64'(wr_en), 64'd1);
        expect_eq("alu_wr_addr", 64'(wr_addr), 64'd3);
        expect_eq("alu_wr_data", wr_data, 64'hA5);
        @(negedge clk);
        #1;
        expect_eq("alu_wr_pulse", 64'(wr_en), 64'd0);

        // ALU write to x0
        alu_valid = 1'b1;
        alu_rd    = '0;
        alu_data  = DW'(64'hFF);
        #1;
        expect_eq("x0_alu_ready", 64'(alu_ready), 64'd1);
        @(negedge clk);
        idle();
        #1;
        expect_eq("x0_wr_en", 64'(wr_en), 64'd0);
        @(negedge clk);
        #1;
        expect_eq("x0_wr_en_late", 64'(wr_en), 64'd0);

        // Three back-to-back LSU results, ALU idle
        qclear();
        for (int k = 0; k < 3; k++) begin
            lsu_valid = 1'b1;
            lsu_rd    = AW'(20 + k);
            lsu_data  = DW'(64'h300 + 64'(k));
            #1;
            expect_eq("lsu3_ready", 64'(lsu_ready), 64'd1);
            @(negedge clk);
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            expect_eq("lsu3_ready_drain", 64'(lsu_ready), 64'd1);
            @(negedge clk);
        end
        #1;
        expect_eq("lsu3_count", 64'(wq_a.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < wq_a.size()) begin
                expect_eq("lsu3_addr", 64'(wq_a[k]), 64'(20 + k));
                expect_eq("lsu3_data", wq_d[k], 64'h300 + 64'(k));
            end
        end

        // ALU and LSU valid every cycle after reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        qclear();
        ai = 0;
        li = 0;
        for (int c = 0; c < 12; c++) begin
            alu_valid = 1'b1;
            alu_rd    = AW'(1 + ai);
            alu_data  = DW'(64'h100 + 64'(ai));
            lsu_valid = 1'b1;
            lsu_rd    = AW'(16 + li);
            lsu_data  = DW'(64'h200 + 64'(li));
            #1;
            hs_a = alu_ready;
            hs_l = lsu_ready;
            @(posedge clk);
            if (hs_a) ai++;
            if (hs_l) li++;
            @(negedge clk);
            #1;
        end
        idle();
        repeat (6) @(negedge clk);
        #1;
        expect_eq("rr_alu_acc", 64'(ai), 64'd6);
        expect_eq("rr_lsu_acc", 64'(li), 64'd7);
        expect_eq("rr_total", 64'(wq_a.size()), 64'(ai + li));
        expect_eq("rr_len", 64'(wq_a.size() >= 8), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < wq_a.size()) begin
                if (i % 2 == 0) begin
                    expect_eq("rr_alu_addr", 64'(wq_a[i]), 64'(1 + i / 2));
                    expect_eq("rr_alu_data", wq_d[i], 64'h100 + 64'(i / 2));
                end else begin
                    expect_eq("rr_lsu_addr", 64'(wq_a[i]), 64'(16 + i / 2));
                    expect_eq("rr_lsu_data", wq_d[i], 64'h200 + 64'(i / 2));
                end
            end
        end

`ifdef RISCV_WB_SCOREBOARD_EN
        // Issue rd 7, LSU writes 7
        @(negedge clk);
        iss_valid = 1'b1;
        iss_rd    = AW'(7);
        @(negedge clk);
        idle();
        #1;
        expect_eq("sb_busy_set", 64'(chk_busy1), 64'd1);
        expect_eq("sb_busy_x0", 64'(chk_busy2), 64'd0);
        lsu_valid = 1'b1;
        lsu_rd    = AW'(7);
        lsu_data  = DW'(64'h77);
        @(negedge clk);
        idle();
        #1;
        expect_eq("sb_busy_hold", 64'(chk_busy1), 64'd1);
        expect_eq("sb_wr_before", 64'(wr_en), 64'd0);
        @(negedge clk);
        #1;
        expect_eq("sb_wr_en", 64'(wr_en), 64'd1);
        expect_eq("sb_wr_addr", 64'(wr_addr), 64'd7);
        expect_eq("sb_busy_clr", 64'(chk_busy1), 64'd0);

        // Re-issue on the same edge as the write
        iss_valid = 1'b1;
        iss_rd    = AW'(7);
        @(negedge clk);
        idle();
        lsu_valid = 1'b1;
        lsu_rd    = AW'(7);
        lsu_data  = DW'(64'h78);
        @(negedge clk);
        idle();
        iss_valid = 1'b1;
        iss_rd    = AW'(7);
        @(negedge clk);
        idle();
        #1;
        expect_eq("sb_race_wr", 64'(wr_en), 64'd1);
        expect_eq("sb_race_busy", 64'(chk_busy1), 64'd1);
        @(negedge clk);
        #1;
        expect_eq("sb_race_keep", 64'(chk_busy1), 64'd1);
`else
        @(negedge clk);
        iss_valid = 1'b1;
        iss_rd    = AW'(7);
        @(negedge clk);
        idle();
        #1;
        expect_eq("nosb_busy1", 64'(chk_busy1), 64'd0);
`endif

        // Reset with two entries buffered
        @(negedge clk);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            alu_valid = 1'b1;
            alu_rd    = AW'(9);
            alu_data  = DW'(64'h900);
            lsu_valid = 1'b1;
            lsu_rd    = AW'(10);
            lsu_data  = DW'(64'hA00);
            #1;
            if (!lsu_ready) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        expect_eq("mrst_full_seen", 64'(seen), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        expect_eq("mrst_lsu_ready", 64'(lsu_ready), 64'd1);
        expect_eq("mrst_wr_en", 64'(wr_en), 64'd0);
        expect_eq("mrst_wr_addr", 64'(wr_addr), 64'd0);
        expect_eq("mrst_busy1", 64'(chk_busy1), 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        qclear();
        repeat (5) @(negedge clk);
        #1;
        expect_eq("mrst_no_write", 64'(wq_a.size()), 64'd0);
        expect_eq("mrst_lsu_ready2", 64'(lsu_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
